// File: rtl/cla_multiword_seq.sv
// Wide add/subtract done one 16-bit slice per cycle on a single shared CLA; result valid NWORDS cycles after accept.
// One op at a time: start_ready only in IDLE; result and flags held in DONE until res_ready.

// 16-bit carry-lookahead adder: 4-bit groups with a second lookahead level over the group carries.
module cla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);
    logic [15:0] g, p;
    logic [16:0] c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k]  = &p[B +: 4];
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    assign gc[0] = c_i;
    assign gc[1] = gg[0] | (gp[0] & gc[0]);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & gc[0]);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

    assign c[16] = gc[4];
    assign s_o   = p ^ c[15:0];
    assign c_o   = c[16];
endmodule

module cla_multiword_seq #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [16*NWORDS-1:0] op_a,
    input  logic [16*NWORDS-1:0] op_b,
    input  logic                 sub,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [16*NWORDS-1:0] result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy
);
    localparam int W  = 16 * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, result_q;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cy_q, carry_out_q, ovf_q, res_valid_q, busy_q;
    logic [15:0]     a_sl, b_sl, sum_sl;
    logic            cout_sl;

    assign a_sl  = a_q[16*idx_q +: 16];
    assign b_sl  = b_q[16*idx_q +: 16];
    assign idx_d = idx_q + 1'b1;

    cla_16bit u_add (
        .a_i (a_sl),
        .b_i (b_sl),
        .c_i (cy_q),
        .s_o (sum_sl),
        .c_o (cout_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        // Subtraction folds into addition: invert B here, +1 via the slice-0 carry-in.
                        a_q     <= op_a;
                        b_q     <= op_b ^ {W{sub}};
                        cy_q    <= sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q[16*idx_q +: 16] <= sum_sl;
                    cy_q                     <= cout_sl;
                    if (idx_q == LAST) begin
                        carry_out_q <= cout_sl;
                        ovf_q       <= a_sl[15] ^ b_sl[15] ^ sum_sl[15] ^ cout_sl;
                        idx_q       <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign carry_out   = carry_out_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;
endmodule
